muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised RV M-extension multiply/divide engine for the EX stage of the 5-stage pipelined core.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU iteratively, radix-2, for XLEN = 32 or 64.
- Drives a stall request into the hazard unit so that IF/ID/EX hold while the operation runs.
- Honours EX flushes from branch/jump redirect.

Parameters:
XLEN, 32, operand/result width; legal values 32 or 64.
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, do not override).

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-low reset (0 = reset).
start  in  1  EX holds a valid M-extension op; held high by the stalled pipeline until done.
funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
srcA  in  XLEN  rs1 operand, already forwarded.
srcB  in  XLEN  rs2 operand, already forwarded.
flush  in  1  FlushE from the hazard unit; aborts any operation.
busy  out  1  1 while in BUSY.
done  out  1  one-cycle pulse; result valid.
result  out  XLEN  final result; holds last value until the next done.
stall_req  out  1  OR'd into StallF/StallD and EX hold.

Behaviour:
- States: IDLE, BUSY, DONE. Reset: state IDLE; busy, done, result, counter and accumulators all 0.
- stall_req = (IDLE & start & ~flush) | BUSY. It is 0 in DONE, so the EX instruction advances at the end of the DONE cycle.
- IDLE, start=1, flush=0: latch funct3 and operand magnitudes, plus sign flags per op (MULHSU: srcA signed, srcB unsigned; *U ops unsigned).
  - Special case → DONE next cycle with result: div-by-zero (DIV/DIVU quotient all ones; REM/REMU = srcA); signed overflow (DIV of -2^(XLEN-1) by -1 = -2^(XLEN-1); REM = 0).
  - Otherwise → BUSY, counter = 0.
- BUSY multiply: shift-add on a 2*XLEN accumulator, one multiplier bit per cycle.
- BUSY divide: restoring shift-subtract, one quotient bit per cycle.
- BUSY exit: after XLEN iterations (counter reaches XLEN-1) → DONE.
- Latency: start first seen in IDLE at cycle T → done at T+XLEN+1 (T+1 for special cases).
- Final sign fix-up and selection happen on the BUSY→DONE edge, registered into result:
  - product negated if operand signs differ (signed ops);
  - quotient negated if signs differ; remainder takes the dividend's sign;
  - MUL selects the low XLEN bits, MULH* the high XLEN bits.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE. start is ignored in DONE.
- flush=1 in any state → IDLE next cycle. No done pulse, result unchanged, stall_req=0 in that cycle. Flush beats start in the same cycle.
- Async reset asserted mid-operation → immediate IDLE; partial results discarded.
- A back-to-back op restarts from IDLE one cycle after DONE; there is no pipelining between ops.

Optional Feature:
Macro FAST_MUL_EN.
- Defined: multiply ops compute the full 2*XLEN product combinationally in the IDLE cycle and go IDLE→DONE, latency 1. Divides are unchanged.
- Undefined: multiplies use the iterative XLEN-cycle path above. No multiplier array is inferred.

Test Plan:
XLEN=32, MUL srcA=7, srcB=0xFFFFFFFD, start at T → done at T+33, result 0xFFFFFFEB, stall_req high T..T+32 and low at T+33.
MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
DIVU 5/0 → done at T+1, result 0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same operands → 0.
flush at BUSY cycle 10 → busy=0 and no done next cycle; a new DIV issued afterwards returns the correct result at the expected latency.
reset driven 0 mid-BUSY → busy, done, stall_req, result = 0 immediately. With FAST_MUL_EN defined, MUL 7×-3 gives done at T+1 with result 0xFFFFFFEB.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV M-extension multiply/divide engine with stall request and EX flush.
// Optional FAST_MUL_EN: single-cycle combinational multiply; divides stay iterative.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall_req
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag, special_res;
  logic                div_zero, div_ovf;
  logic [XLEN:0]       mul_sum, rem_sh, rem_new;
  logic                div_ge;
  logic [2*XLEN-1:0]   step;

  // Sign correction and high/low selection applied to a magnitude result.
  function automatic logic [XLEN-1:0] fixup(input logic [2:0] op, input logic [2*XLEN-1:0] acc,
                                            input logic neg_res, input logic neg_rem);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    prod = neg_res ? -acc : acc;
    quot = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (!op[2]) fixup = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else        fixup = op[1] ? rem : quot;
  endfunction

  always_comb begin
    is_div      = funct3[2];
    a_signed    = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    b_signed    = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
    a_neg       = a_signed & srcA[XLEN-1];
    b_neg       = b_signed & srcB[XLEN-1];
    a_mag       = a_neg ? -srcA : srcA;
    b_mag       = b_neg ? -srcB : srcB;
    div_zero    = is_div & (srcB == '0);
    div_ovf     = is_div & ~funct3[0] & (srcA == {1'b1, {(XLEN-1){1'b0}}}) & (srcB == '1);
    if (div_zero) special_res = funct3[1] ? srcA : '1;
    else          special_res = funct3[1] ? '0 : srcA;
  end

  // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    rem_sh  = acc_q[2*XLEN-1:XLEN-1];
    div_ge  = (rem_sh >= {1'b0, opb_q});
    rem_new = div_ge ? (rem_sh - {1'b0, opb_q}) : rem_sh;
    if (op_q[2]) step = {rem_new[XLEN-1:0], acc_q[XLEN-2:0], div_ge};
    else         step = {mul_sum, acc_q[XLEN-1:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = funct3;
          opb_d     = b_mag;
          acc_d     = {{XLEN{1'b0}}, a_mag};
          cnt_d     = '0;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (div_zero || div_ovf) begin
            state_d  = S_DONE;
            result_d = special_res;
          end
`ifdef FAST_MUL_EN
          else if (!is_div) begin
            state_d  = S_DONE;
            result_d = fixup(funct3, {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag},
                             a_neg ^ b_neg, a_neg);
          end
`endif
          else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        acc_d = step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN-1)) begin
          state_d  = S_DONE;
          result_d = fixup(op_q, step, neg_res_q, neg_rem_q);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Flush wins over everything, including a start in the same cycle.
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_comb begin
    busy      = (state_q == S_BUSY);
    done      = (state_q == S_DONE) & ~flush;
    result    = result_q;
    stall_req = reset & ~flush & (((state_q == S_IDLE) & start) | (state_q == S_BUSY));
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): vector table plus flush/reset sequences.
// Honours FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_unit;

  localparam int XLEN = 32;
`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;

  logic            clk;
  logic            reset;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            stall_req;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          lat_q[$];

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .srcA(srcA), .srcB(srcB), .flush(flush), .busy(busy), .done(done),
    .result(result), .stall_req(stall_req)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Drive one op, push its expectation, then pop and compare when done appears.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int          t0;
    int          stall_bad;
    bit          got;
    logic [31:0] e;
    int          l;
    @(posedge clk); #1;
    start = 1'b1; funct3 = f; srcA = a; srcB = b;
    t0 = cyc;
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    got = 1'b0;
    stall_bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (!stall_req) stall_bad++;
    end
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done within 200 cycles, expected result 0x%0h", name, e);
    end else begin
      check({name, " result"}, 64'(result), 64'(e));
      check({name, " latency"}, 64'(cyc - t0), 64'(l));
      check({name, " stall"}, {31'd0, stall_req, 32'(stall_bad)}, 64'd0);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; funct3 = '0; srcA = '0; srcB = '0; flush = 1'b0;

    vecs.push_back('{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT});
    vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT});
    vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT});
    vecs.push_back('{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT});
    vecs.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT});
    vecs.push_back('{3'b011, 32'h80000000, 32'd4,        32'd2,        MUL_LAT});
    vecs.push_back('{3'b000, 32'd1234,     32'd5678,     32'h006AE9BC, MUL_LAT});
    vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT});
    vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT});
    vecs.push_back('{3'b101, 32'd100,      32'd7,        32'd14,       DIV_LAT});
    vecs.push_back('{3'b111, 32'd100,      32'd7,        32'd2,        DIV_LAT});
    vecs.push_back('{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT});
    vecs.push_back('{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        DIV_LAT});
    vecs.push_back('{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back('{3'b110, 32'd5,        32'd0,        32'd5,        1});
    vecs.push_back('{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back('{3'b111, 32'd5,        32'd0,        32'd5,        1});
    vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1});
    vecs.push_back('{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        DIV_LAT});
    vecs.push_back('{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, DIV_LAT});
    vecs.push_back('{3'b101, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        DIV_LAT});
    vecs.push_back('{3'b111, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        DIV_LAT});

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset stall_req", 64'(stall_req), 64'd0);
    check("reset result", 64'(result), 64'd0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d f%0d", i, vecs[i].f), vecs[i].f, vecs[i].a, vecs[i].b,
             vecs[i].exp, vecs[i].lat);
    end

    // Flush in the tenth BUSY cycle aborts the op and leaves result untouched.
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b101; srcA = 32'd1000; srcB = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush stall_req", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    check("flush busy", 64'(busy), 64'd0);
    check("flush done", 64'(done), 64'd0);
    check("flush result held", 64'(result), 64'd1);
    run_op("div after flush", 3'b100, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, DIV_LAT);
    run_op("rem after flush", 3'b110, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, DIV_LAT);

    // Asynchronous reset mid-BUSY clears outputs without waiting for a clock edge.
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b101; srcA = 32'd100; srcB = 32'd7;
    repeat (5) @(posedge clk);
    #2;
    check("busy before reset", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset done", 64'(done), 64'd0);
    check("async reset stall_req", 64'(stall_req), 64'd0);
    check("async reset result", 64'(result), 64'd0);
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    run_op("mul after reset", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
